// File: rtl/cmplx_acc_pkg.sv
// Shared constants and types for the complex multiply/accumulate datapath.
// Word sizes here track the upstream complex multiplier's result format.
package cmplx_acc_pkg;

  // Word-size constants shared with the complex multiplier
  localparam int MULT_OPERAND_WIDTH = 4;
  localparam int MULT_RESULT_WIDTH  = 2 * MULT_OPERAND_WIDTH;

  // Accumulator defaults
  localparam int WORD_WIDTH_DEF = MULT_RESULT_WIDTH;
  localparam int ACC_WIDTH_DEF  = 16;
  localparam int LEN_DEF        = 4;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  // Counter must be able to hold the value LEN itself.
  function automatic int cnt_width(input int len);
    return (len < 1) ? 1 : $clog2(len + 1);
  endfunction

endpackage

// File: rtl/cmplx_acc_sat_add.sv
// Combinational saturating add: signed accumulator plus sign-extended word.
// Flags when the result had to be clamped to the representable range.
module sat_add #(
  parameter int ACC_WIDTH  = 16,
  parameter int WORD_WIDTH = 8
) (
  input  logic [ACC_WIDTH-1:0]  acc,
  input  logic [WORD_WIDTH-1:0] addend,
  output logic [ACC_WIDTH-1:0]  sum,
  output logic                  sat
);

  localparam int EXT = ACC_WIDTH + 1 - WORD_WIDTH;

  localparam logic [ACC_WIDTH-1:0] MAX_VAL = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] MIN_VAL = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH:0] wide;

  always_comb begin
    wide = {acc[ACC_WIDTH-1], acc} + {{EXT{addend[WORD_WIDTH-1]}}, addend};
    // One guard bit is enough: the two top bits disagree only on overflow,
    // and the guard bit then gives the true sign of the result.
    sat = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];
    if (sat) begin
      sum = wide[ACC_WIDTH] ? MIN_VAL : MAX_VAL;
    end else begin
      sum = wide[ACC_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/cmplx_acc.sv
// Frame accumulator for complex products: sums LEN samples with saturation,
// then holds the result behind a valid/ready handshake until taken.
module cmplx_acc
  import cmplx_acc_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int LEN        = LEN_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WORD_WIDTH-1:0]         in_re,
  input  logic [WORD_WIDTH-1:0]         in_im,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_WIDTH-1:0]          out_re,
  output logic [ACC_WIDTH-1:0]          out_im,
  output logic                          out_ovf,
  output logic [cnt_width(LEN)-1:0]     count
);

  localparam int CW = cnt_width(LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(LEN - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(LEN);

  acc_state_t           state_q, state_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 ovf_q, ovf_d;
  logic [CW-1:0]        count_q, count_d;
  logic [ACC_WIDTH-1:0] acc_q [2];
  logic [ACC_WIDTH-1:0] acc_d [2];

  logic [WORD_WIDTH-1:0] in_word [2];
  logic [ACC_WIDTH-1:0]  sum_w   [2];
  logic                  sat_w   [2];
  logic                  accept;

  assign in_word[0] = in_re;
  assign in_word[1] = in_im;

  // Lane 0 is the real part, lane 1 the imaginary part.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      sat_add #(
        .ACC_WIDTH (ACC_WIDTH),
        .WORD_WIDTH(WORD_WIDTH)
      ) u_sat_add (
        .acc   (acc_q[gi]),
        .addend(in_word[gi]),
        .sum   (sum_w[gi]),
        .sat   (sat_w[gi])
      );
    end
  endgenerate

  // in_ready_q is high exactly in ACCUM, so it doubles as the accept gate.
  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    count_d     = count_q;
    for (int i = 0; i < 2; i++) begin
      acc_d[i] = acc_q[i];
    end

    case (state_q)
      ACCUM: begin
        if (accept) begin
          for (int i = 0; i < 2; i++) begin
            acc_d[i] = sum_w[i];
          end
          ovf_d = ovf_q | sat_w[0] | sat_w[1];
          if (count_q == LAST_IDX) begin
            count_d     = FULL_CNT;
            state_d     = HOLD;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          for (int i = 0; i < 2; i++) begin
            acc_d[i] = '0;
          end
          ovf_d       = 1'b0;
          count_d     = '0;
          state_d     = ACCUM;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ACCUM;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
      for (int i = 0; i < 2; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
      for (int i = 0; i < 2; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_re    = acc_q[0];
  assign out_im    = acc_q[1];
  assign out_ovf   = ovf_q;
  assign count     = count_q;

endmodule

// File: tb/tb_cmplx_acc.sv
// Self-checking bench for cmplx_acc: a saturating reference model pushes
// expected frame sums into a scoreboard, popped when out_valid appears.
module tb_cmplx_acc;

  localparam int WW   = 8;
  localparam int AW   = 9;
  localparam int LEN  = 4;
  localparam int CW   = $clog2(LEN + 1);
  localparam int AMAX = 255;
  localparam int AMIN = -256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WW-1:0] in_re = '0;
  logic [WW-1:0] in_im = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_re;
  logic [AW-1:0] out_im;
  logic          out_ovf;
  logic [CW-1:0] count;

  cmplx_acc #(
    .WORD_WIDTH(WW),
    .ACC_WIDTH (AW),
    .LEN       (LEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_re    (in_re),
    .in_im    (in_im),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_re   (out_re),
    .out_im   (out_im),
    .out_ovf  (out_ovf),
    .count    (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int re;
    int im;
    int ovf;
  } res_t;

  res_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_re, m_im, m_cnt, m_ovf;

  int s2_re[4] = '{10, 20, -7, 1};
  int s2_im[4] = '{-3, 5, 1, 1};

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_re = 0; m_im = 0; m_cnt = 0; m_ovf = 0;
  endtask

  function automatic int clamp(input int v);
    if (v > AMAX) return AMAX;
    if (v < AMIN) return AMIN;
    return v;
  endfunction

  task automatic model_add(input int re, input int im);
    if (clamp(m_re + re) != m_re + re || clamp(m_im + im) != m_im + im) m_ovf = 1;
    m_re = clamp(m_re + re);
    m_im = clamp(m_im + im);
    m_cnt++;
    if (m_cnt == LEN) sb_q.push_back('{m_re, m_im, m_ovf});
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_re"},  $signed(out_re), m_re);
    chk({tag, "_im"},  $signed(out_im), m_im);
    chk({tag, "_cnt"}, count, m_cnt);
    chk({tag, "_ovf"}, out_ovf, m_ovf);
  endtask

  task automatic send(input int re, input int im, input int gap);
    int w;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_re    = WW'(re);
    in_im    = WW'(im);
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    model_add(re, im);
    $display("accept (%0d,%0d) -> count=%0d re=%0d im=%0d ovf=%0d",
             re, im, count, $signed(out_re), $signed(out_im), out_ovf);
    if (m_cnt == LEN) chk("valid_latency", out_valid, 1);
    else begin
      check_state("partial");
      chk("partial_valid", out_valid, 0);
    end
  endtask

  task automatic drain(input string tag);
    res_t e;
    int   w;
    w = 0;
    while (!out_valid && w < 20) begin
      tick();
      w++;
    end
    if (!out_valid) chk({tag, "_valid_timeout"}, 0, 1);
    else if (sb_q.size() == 0) chk({tag, "_sb_empty"}, 1, 0);
    else begin
      e = sb_q.pop_front();
      $display("result %s: re=%0d im=%0d ovf=%0d count=%0d", tag,
               $signed(out_re), $signed(out_im), out_ovf, count);
      chk({tag, "_re"},    $signed(out_re), e.re);
      chk({tag, "_im"},    $signed(out_im), e.im);
      chk({tag, "_ovf"},   out_ovf, e.ovf);
      chk({tag, "_cnt"},   count, LEN);
      chk({tag, "_ready"}, in_ready, 0);
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_cnt"},   count, 0);
    chk({tag, "_re"},    $signed(out_re), 0);
    chk({tag, "_im"},    $signed(out_im), 0);
    chk({tag, "_ovf"},   out_ovf, 0);
    chk({tag, "_ready"}, in_ready, 1);
    chk({tag, "_valid"}, out_valid, 0);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    model_clear();
    $display("handshake %s", tag);
    check_cleared(tag);
  endtask

  initial begin
    model_clear();

    // Reset held two cycles
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    $display("reset released");
    check_cleared("reset");

    // Back-to-back frame
    for (int i = 0; i < 4; i++) send(s2_re[i], s2_im[i], 0);
    drain("b2b");

    // Backpressure while a sample is offered, then handshake
    in_valid = 1'b1;
    in_re    = WW'(99);
    in_im    = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      $display("hold cycle %0d: re=%0d im=%0d count=%0d", i,
               $signed(out_re), $signed(out_im), count);
      chk("hold_re",    $signed(out_re), 24);
      chk("hold_im",    $signed(out_im), 4);
      chk("hold_cnt",   count, LEN);
      chk("hold_valid", out_valid, 1);
    end
    handshake("hs_pending");
    tick();
    in_valid = 1'b0;
    model_add(99, 0);
    $display("pending sample accepted: count=%0d re=%0d", count, $signed(out_re));
    check_state("pending");
    for (int i = 0; i < 3; i++) send(0, 0, 0);
    drain("pending_frame");
    handshake("hs2");

    // Saturation in both directions
    for (int i = 0; i < 4; i++) send(127, -128, 0);
    drain("sat");
    handshake("hs3");

    // Random bubbles between samples
    for (int i = 0; i < 4; i++) send(s2_re[i], s2_im[i], int'($urandom_range(0, 3)));
    drain("gaps");
    handshake("hs4");

    // Reset mid-frame discards partial sums
    send(50, 50, 0);
    send(50, 50, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    sb_q.delete();
    $display("mid-frame reset");
    check_cleared("midrst");
    for (int i = 0; i < 4; i++) send(s2_re[i], s2_im[i], 0);
    drain("after_rst");
    handshake("hs5");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cmplx_acc.md
Name: cmplx_acc

Overview:
- Downstream consumer of the complex multiplier's re/im result words.
- Accumulates a frame of LEN complex products into a saturating complex sum, i.e. a complex dot product.
- Presents the sum with a valid/ready handshake to the display/output stage.
- Holds the result until it is acknowledged, then starts the next frame.

Parameters:
WORD_WIDTH, 8, width of signed input re/im words (matches multiplier result word)
ACC_WIDTH, 16, width of signed accumulator and output words; must be >= WORD_WIDTH
LEN, 4, products per frame; >= 1

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input sample present
in_ready  out  1  block accepts sample this cycle
in_re  in  WORD_WIDTH  signed real part of product
in_im  in  WORD_WIDTH  signed imaginary part of product
out_valid  out  1  frame sum available
out_ready  in  1  consumer takes sum this cycle
out_re  out  ACC_WIDTH  signed accumulated real sum
out_im  out  ACC_WIDTH  signed accumulated imaginary sum
out_ovf  out  1  saturation occurred at least once in this frame (sticky per frame)
count  out  clog2(LEN+1)  samples accepted in current frame

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high, sampled on the clk rising edge.
- Reset values: state=ACCUM, in_ready=1, out_valid=0, out_re=out_im=0, out_ovf=0, count=0. Reset mid-frame or mid-hold discards all partial or held data.
- FSM, two states:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept: in_valid && in_ready on a rising edge.
- Accept in ACCUM with count < LEN-1:
  - acc_re <= sat(acc_re + sext(in_re)); acc_im likewise.
  - count++.
- Accept in ACCUM with count == LEN-1:
  - Performs the same update.
  - count <= LEN.
  - Next state is HOLD; out_valid goes high the cycle after the final accept.
- LEN=1: every accept goes directly to HOLD.
- Latency: 1 cycle from final accepted sample to out_valid.
- out_re/out_im are the accumulator registers themselves. They are stable throughout HOLD and change only on accepts or on clear.
- HOLD and out_ready=1 (the handshake):
  - Next cycle: state=ACCUM, accumulators=0, count=0, out_ovf=0.
  - in_ready is 0 during the handshake cycle, so an in_valid in that cycle is not accepted; it is accepted the following cycle.
- HOLD and out_ready=0: all state frozen, in_valid ignored.
- in_valid=0 in ACCUM: no change (bubbles allowed, any length).
- Saturating add:
  - Compute the sum at ACC_WIDTH+1 bits.
  - If the sum exceeds 2^(ACC_WIDTH-1)-1, clamp to that value.
  - If the sum is below -2^(ACC_WIDTH-1), clamp to that value.
  - Any clamp on either component sets out_ovf, which stays set until the frame is cleared.
  - Saturation does not wrap; later additions continue from the clamped value.
- in_re/in_im are interpreted as signed two's complement and sign-extended to ACC_WIDTH.

Decomposition:
- Shared package constants: WORD_WIDTH and ACC_WIDTH defaults, alongside the existing word-size constants.
- Shared package typedef: the state enum {ACCUM, HOLD}.
- One sub-module, sat_add, instantiated twice (re, im):
  - Inputs: signed ACC_WIDTH accumulator and signed WORD_WIDTH addend.
  - Outputs: clamped ACC_WIDTH sum and a 1-bit sat flag.
  - Purely combinational, parameterised by both widths.
- FSM, counter and registers live in cmplx_acc.

Test Plan:
Test parameters: WORD_WIDTH=8, ACC_WIDTH=9, LEN=4 (range -256..255).
1. Assert rst 2 cycles, then release -> in_ready=1, out_valid=0, out_re=out_im=0, out_ovf=0, count=0.
2. Back-to-back samples (10,-3),(20,5),(-7,1),(1,1) -> out_valid=1 the cycle after the 4th accept; out_re=24, out_im=4, out_ovf=0, count=4, in_ready=0.
3. Four samples (127,-128) -> re partial sums 127, 254, 255, 255; im partial sums -128, -256, -256, -256; final out_re=255, out_im=-256, out_ovf=1.
4. After test 2, out_ready=0 for 5 cycles with in_valid=1 and in_re=99 -> outputs stay 24/4, nothing accepted. Then out_ready=1 for 1 cycle -> next cycle count=0, sums 0, in_ready=1, out_ovf=0. The 99 sample is accepted the cycle after that.
5. Test 2 samples with random 0-3 cycle in_valid gaps -> identical result 24/4, out_valid still 1 cycle after the 4th accept.
6. Accept (50,50),(50,50), pulse rst mid-frame, then send test 2 samples -> count restarts from 0, result 24/4 with no residue from the discarded samples.
